// File: rtl/atm_pkg.sv
// Shared definitions for the ATM ledger scheduler: field widths, opcodes
// and the transaction FSM state encoding.
package atm_pkg;

  localparam int BAL_W = 16;
  localparam int AMT_W = 11;
  localparam int IDX_W = 4;

  localparam logic [1:0] OP_BALANCE  = 2'b00;
  localparam logic [1:0] OP_WITHDRAW = 2'b01;
  localparam logic [1:0] OP_DEPOSIT  = 2'b10;
  localparam logic [1:0] OP_TRANSFER = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/atm_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting terminal at or after the
// pointer position, wrapping around. Purely combinational, one-hot grant.
module atm_rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  // Scan from the pointer upwards and grant the first active request
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(pointer) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_ledger_scheduler.sv
// ATM ledger scheduler: arbitrates terminal requests round-robin and runs one
// ledger operation at a time through IDLE -> READ -> EXEC -> WRITE -> RESP.
// Optional feature macro: ATM_TXN_COUNT_EN adds a 16-bit successful
// transaction counter on port txn_count.
module atm_ledger_scheduler
  import atm_pkg::*;
#(
  parameter int NUM_TERM = 4,
  parameter int NUM_ACC  = 10,
  parameter int INIT_BAL = 500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_TERM-1:0]       req,
  input  logic [2*NUM_TERM-1:0]     op,
  input  logic [IDX_W*NUM_TERM-1:0] src_idx,
  input  logic [IDX_W*NUM_TERM-1:0] dst_idx,
  input  logic [AMT_W*NUM_TERM-1:0] amount,
  output logic [NUM_TERM-1:0]       gnt,
  output logic [NUM_TERM-1:0]       done,
  output logic                      err,
  output logic [BAL_W-1:0]          bal_out,
  output logic                      busy
`ifdef ATM_TXN_COUNT_EN
  ,
  output logic [BAL_W-1:0]          txn_count
`endif
);

  localparam int PW = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;

  state_t               state;
  logic [PW-1:0]        rr_ptr;
  logic [NUM_TERM-1:0]  arb_grant;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        next_ptr;
  logic [NUM_TERM-1:0]  winner;

  logic [1:0]           sel_op;
  logic [IDX_W-1:0]     sel_src;
  logic [IDX_W-1:0]     sel_dst;
  logic [AMT_W-1:0]     sel_amt;

  logic [1:0]           op_q;
  logic [IDX_W-1:0]     src_q;
  logic [IDX_W-1:0]     dst_q;
  logic [AMT_W-1:0]     amt_q;

  logic [BAL_W-1:0]     ledger [NUM_ACC];
  logic [BAL_W-1:0]     src_bal;
  logic [BAL_W-1:0]     dst_bal;

  logic                 src_ok;
  logic                 dst_ok;
  logic [BAL_W-1:0]     amt_ext;
  logic [BAL_W:0]       src_sum;
  logic [BAL_W:0]       dst_sum;

  logic                 x_err;
  logic [BAL_W-1:0]     x_src;
  logic [BAL_W-1:0]     x_dst;
  logic                 x_wsrc;
  logic                 x_wdst;

  logic                 err_q;
  logic [BAL_W-1:0]     new_src_q;
  logic [BAL_W-1:0]     new_dst_q;
  logic                 wsrc_q;
  logic                 wdst_q;

  atm_rr_arbiter #(.N(NUM_TERM)) u_arb (
    .req     (req),
    .pointer (rr_ptr),
    .grant   (arb_grant)
  );

  assign busy = (state != ST_IDLE);

  // Winner index and its operand fields, selected from the one-hot grant
  always_comb begin
    grant_idx = '0;
    sel_op    = '0;
    sel_src   = '0;
    sel_dst   = '0;
    sel_amt   = '0;
    for (int i = 0; i < NUM_TERM; i++) begin
      if (arb_grant[i]) begin
        grant_idx = PW'(i);
        sel_op    = op[2*i +: 2];
        sel_src   = src_idx[IDX_W*i +: IDX_W];
        sel_dst   = dst_idx[IDX_W*i +: IDX_W];
        sel_amt   = amount[AMT_W*i +: AMT_W];
      end
    end
  end

  assign next_ptr = (int'(grant_idx) == NUM_TERM - 1) ? '0 : grant_idx + PW'(1);

  assign src_ok  = (int'(src_q) < NUM_ACC);
  assign dst_ok  = (int'(dst_q) < NUM_ACC);
  assign amt_ext = BAL_W'(amt_q);
  assign src_sum = {1'b0, src_bal} + {1'b0, amt_ext};
  assign dst_sum = {1'b0, dst_bal} + {1'b0, amt_ext};

  // Operation outcome from the captured operands and the balances read in READ
  always_comb begin
    x_err  = 1'b0;
    x_src  = src_bal;
    x_dst  = dst_bal;
    x_wsrc = 1'b0;
    x_wdst = 1'b0;
    if (!src_ok || (op_q == OP_TRANSFER && !dst_ok)) begin
      x_err = 1'b1;
    end else begin
      case (op_q)
        OP_WITHDRAW: begin
          if (amt_ext > src_bal) begin
            x_err = 1'b1;
          end else begin
            x_src  = src_bal - amt_ext;
            x_wsrc = 1'b1;
          end
        end
        OP_DEPOSIT: begin
          if (src_sum[BAL_W]) begin
            x_err = 1'b1;
          end else begin
            x_src  = src_sum[BAL_W-1:0];
            x_wsrc = 1'b1;
          end
        end
        OP_TRANSFER: begin
          if (amt_ext > src_bal || (src_q != dst_q && dst_sum[BAL_W])) begin
            x_err = 1'b1;
          end else if (src_q != dst_q) begin
            x_src  = src_bal - amt_ext;
            x_dst  = dst_sum[BAL_W-1:0];
            x_wsrc = 1'b1;
            x_wdst = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Transaction FSM with registered outputs and the ledger storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      bal_out   <= '0;
      rr_ptr    <= '0;
      winner    <= '0;
      op_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      amt_q     <= '0;
      src_bal   <= '0;
      dst_bal   <= '0;
      err_q     <= 1'b0;
      new_src_q <= '0;
      new_dst_q <= '0;
      wsrc_q    <= 1'b0;
      wdst_q    <= 1'b0;
      for (int a = 0; a < NUM_ACC; a++) begin
        ledger[a] <= BAL_W'(INIT_BAL);
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state  <= ST_READ;
            gnt    <= arb_grant;
            winner <= arb_grant;
            rr_ptr <= next_ptr;
            op_q   <= sel_op;
            src_q  <= sel_src;
            dst_q  <= sel_dst;
            amt_q  <= sel_amt;
          end
        end
        ST_READ: begin
          gnt     <= '0;
          src_bal <= src_ok ? ledger[src_q] : '0;
          dst_bal <= dst_ok ? ledger[dst_q] : '0;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          err_q     <= x_err;
          new_src_q <= x_src;
          new_dst_q <= x_dst;
          wsrc_q    <= x_wsrc;
          wdst_q    <= x_wdst;
          state     <= ST_WRITE;
        end
        ST_WRITE: begin
          if (wsrc_q) begin
            ledger[src_q] <= new_src_q;
          end
          if (wdst_q) begin
            ledger[dst_q] <= new_dst_q;
          end
          done    <= winner;
          err     <= err_q;
          bal_out <= new_src_q;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          done  <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ATM_TXN_COUNT_EN
  // Count successful operations as they enter RESP, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count <= '0;
    end else if (state == ST_WRITE && !err_q) begin
      txn_count <= txn_count + BAL_W'(1);
    end
  end
`endif

endmodule
